// File: rtl/bn128_fp2_pnt_scl_deser_pkg.sv
// Shared BN128 field/point types used by the G2 packet datapath.
// fp2_pnt_scl_t is laid out so that beat k of a packet lands at bits [k*256 +: 256].
package bn128_pkg;

  localparam int FE_BITS   = 256;
  localparam int PKT_BEATS = 7;

  typedef logic [FE_BITS-1:0] fe_t;

  typedef struct packed {
    fe_t c1;
    fe_t c0;
  } fe2_t;

  typedef struct packed {
    fe2_t z;
    fe2_t y;
    fe2_t x;
  } fp2_jb_point_t;

  typedef struct packed {
    fp2_jb_point_t pnt;
    fe_t           scl;
  } fp2_pnt_scl_t;

  // Beat position inside a packet; also the deserializer's state.
  typedef enum logic [2:0] {
    BEAT_SCL = 3'd0,
    BEAT_XC0 = 3'd1,
    BEAT_XC1 = 3'd2,
    BEAT_YC0 = 3'd3,
    BEAT_YC1 = 3'd4,
    BEAT_ZC0 = 3'd5,
    BEAT_ZC1 = 3'd6
  } beat_e;

  localparam fe_t CONST_1 = fe_t'(1);

endpackage

// File: rtl/bn128_fp2_pnt_scl_deser_if.sv
// Framed valid/ready stream: master drives data and framing, slave drives rdy.
interface if_axi_stream #(
  parameter int DAT_BITS = 256,
  parameter int CTL_BITS = 1
);

  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;
  logic                val;
  logic                sop;
  logic                eop;
  logic                rdy;

  modport master (output dat, ctl, val, sop, eop, input rdy);
  modport slave  (input dat, ctl, val, sop, eop, output rdy);

endinterface

// File: rtl/bn128_fp2_pnt_scl_deser.sv
// Reassembles 7-beat G2 scalar+point packets into one wide word, dropping and
// counting malformed packets, and tags batch boundaries on the output.
module bn128_fp2_pnt_scl_deser
  import bn128_pkg::*;
#(
  parameter int DAT_BITS = $bits(fe_t),
  parameter int BEATS    = PKT_BEATS,
  parameter int ERR_BITS = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [63:0]         i_num_in,
  if_axi_stream.slave         i_pnt_scl_if,
  if_axi_stream.master        o_scl_pnt_if,
  output logic [ERR_BITS-1:0] o_err_cnt
);

  beat_e                          cnt;
  beat_e                          cnt_nxt;
  logic [BEATS-2:0][DAT_BITS-1:0] asm_q;
  logic [63:0]                    batch_cnt;
  logic                           beat_acc;
  logic                           slot_free;
  logic                           err_hit;
  logic                           store;
  logic [2:0]                     store_idx;
  logic                           pkt_done;
  logic                           batch_last;

  // Only the final beat needs the output slot, so earlier beats never stall.
  assign slot_free        = ~o_scl_pnt_if.val || o_scl_pnt_if.rdy;
  assign i_pnt_scl_if.rdy = (cnt != BEAT_ZC1) || slot_free;
  assign beat_acc         = i_pnt_scl_if.val && i_pnt_scl_if.rdy;
  assign store_idx        = i_pnt_scl_if.sop ? 3'd0 : 3'(cnt);
  assign batch_last       = (i_num_in != 64'd0) && (batch_cnt == i_num_in - 64'd1);

  always_comb begin
    cnt_nxt  = cnt;
    err_hit  = 1'b0;
    store    = 1'b0;
    pkt_done = 1'b0;
    if (beat_acc) begin
      if (i_pnt_scl_if.sop && i_pnt_scl_if.eop) begin
        err_hit = 1'b1;
        cnt_nxt = BEAT_SCL;
      end else if (i_pnt_scl_if.sop) begin
        // A sop always restarts assembly; anything half-built is abandoned.
        err_hit = (cnt != BEAT_SCL);
        store   = 1'b1;
        cnt_nxt = BEAT_XC0;
      end else if (cnt == BEAT_SCL) begin
        err_hit = 1'b1;
      end else if (cnt != BEAT_ZC1) begin
        if (i_pnt_scl_if.eop) begin
          err_hit = 1'b1;
          cnt_nxt = BEAT_SCL;
        end else begin
          store   = 1'b1;
          cnt_nxt = beat_e'(cnt + 3'd1);
        end
      end else begin
        cnt_nxt  = BEAT_SCL;
        pkt_done = i_pnt_scl_if.eop;
        err_hit  = ~i_pnt_scl_if.eop;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (store) asm_q[store_idx] <= i_pnt_scl_if.dat;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt               <= BEAT_SCL;
      batch_cnt         <= '0;
      o_err_cnt         <= '0;
      o_scl_pnt_if.val  <= 1'b0;
      o_scl_pnt_if.sop  <= 1'b0;
      o_scl_pnt_if.eop  <= 1'b0;
      o_scl_pnt_if.dat  <= '0;
      o_scl_pnt_if.ctl  <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (err_hit && (o_err_cnt != '1)) o_err_cnt <= o_err_cnt + ERR_BITS'(1);
      // A completing packet refills the slot in the same cycle it drains.
      if (pkt_done) begin
        o_scl_pnt_if.val <= 1'b1;
        o_scl_pnt_if.dat <= {i_pnt_scl_if.dat, asm_q};
        o_scl_pnt_if.ctl <= i_pnt_scl_if.ctl;
        o_scl_pnt_if.sop <= (batch_cnt == 64'd0);
        o_scl_pnt_if.eop <= batch_last;
        batch_cnt        <= batch_last ? 64'd0 : batch_cnt + 64'd1;
      end else if (o_scl_pnt_if.rdy) begin
        o_scl_pnt_if.val <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bn128_fp2_pnt_scl_deser.sv
// Directed + randomized bench for the G2 packet deserializer, checked against
// a list-based packet model with a batch counter and saturating error count.
module tb_bn128_fp2_pnt_scl_deser;
  import bn128_pkg::*;

  localparam int PKT_W = 256 * 7;

  typedef struct {
    logic [PKT_W-1:0] dat;
    logic             sop;
    logic             eop;
  } exp_t;

  logic        i_clk;
  logic        i_rst;
  logic [63:0] num_in;
  logic [15:0] err_cnt;
  logic [1:0]  sat_err;

  if_axi_stream #(.DAT_BITS(256))   in_if ();
  if_axi_stream #(.DAT_BITS(PKT_W)) out_if ();
  if_axi_stream #(.DAT_BITS(256))   sat_in_if ();
  if_axi_stream #(.DAT_BITS(PKT_W)) sat_out_if ();

  bn128_fp2_pnt_scl_deser dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_num_in     (num_in),
    .i_pnt_scl_if (in_if),
    .o_scl_pnt_if (out_if),
    .o_err_cnt    (err_cnt)
  );

  bn128_fp2_pnt_scl_deser #(.ERR_BITS(2)) dut_sat (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_num_in     (num_in),
    .i_pnt_scl_if (sat_in_if),
    .o_scl_pnt_if (sat_out_if),
    .o_err_cnt    (sat_err)
  );

  int              n_checks;
  int              n_errors;
  fe_t             part_q[$];
  exp_t            exp_q[$];
  int              model_err;
  longint unsigned model_batch;
  time             out_times[$];
  bit              rnd_rdy;
  bit              rdy_fixed;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic fe_t rand_fe();
    fe_t r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [15:0] exp_err();
    return (model_err > 65535) ? 16'hFFFF : 16'(model_err);
  endfunction

  // Model: a valid packet is sop, five plain beats, then eop on the seventh.
  function automatic void model_beat(input fe_t d, input logic s, input logic e);
    exp_t x;
    if (s && e) begin
      model_err++;
      part_q.delete();
    end else if (s) begin
      if (part_q.size() != 0) model_err++;
      part_q.delete();
      part_q.push_back(d);
    end else if (part_q.size() == 0) begin
      model_err++;
    end else if (part_q.size() < 6) begin
      if (e) begin
        model_err++;
        part_q.delete();
      end else begin
        part_q.push_back(d);
      end
    end else begin
      if (e) begin
        part_q.push_back(d);
        for (int k = 0; k < 7; k++) x.dat[k*256 +: 256] = part_q[k];
        x.sop = (model_batch == 0);
        x.eop = (num_in != 0) && (model_batch == num_in - 1);
        model_batch = x.eop ? 0 : model_batch + 1;
        exp_q.push_back(x);
      end else begin
        model_err++;
      end
      part_q.delete();
    end
  endfunction

  task automatic monitor_loop();
    exp_t             e;
    bit               hold_v = 0;
    logic [PKT_W-1:0] hold_dat = '0;
    logic             hold_sop = 0;
    logic             hold_eop = 0;
    forever begin
      @(negedge i_clk);
      #2;
      if (i_rst || !out_if.val) begin
        hold_v = 0;
      end else begin
        if (hold_v) begin
          checkOutput("hold_dat_stable", 256'(out_if.dat === hold_dat), 256'd1);
          checkOutput("hold_sop_stable", 256'(out_if.sop), 256'(hold_sop));
          checkOutput("hold_eop_stable", 256'(out_if.eop), 256'(hold_eop));
        end
        if (out_if.rdy) begin
          hold_v = 0;
          out_times.push_back($time);
          checkOutput("out_expected", 256'(exp_q.size() != 0), 256'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < 7; k++)
              checkOutput($sformatf("out_beat%0d", k), out_if.dat[k*256 +: 256], e.dat[k*256 +: 256]);
            checkOutput("out_sop", 256'(out_if.sop), 256'(e.sop));
            checkOutput("out_eop", 256'(out_if.eop), 256'(e.eop));
          end
        end else begin
          hold_v   = 1;
          hold_dat = out_if.dat;
          hold_sop = out_if.sop;
          hold_eop = out_if.eop;
        end
      end
    end
  endtask

  task automatic rdy_loop();
    forever begin
      @(negedge i_clk);
      out_if.rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    end
  endtask

  task automatic applyStimulus(input fe_t d, input logic s, input logic e);
    bit ok = 0;
    in_if.dat = d;
    in_if.sop = s;
    in_if.eop = e;
    in_if.ctl = '0;
    in_if.val = 1'b1;
    for (int w = 0; w < 300 && !ok; w++) begin
      @(negedge i_clk);
      #3;
      ok = in_if.rdy;
      @(posedge i_clk);
    end
    #1;
    in_if.val = 1'b0;
    checkOutput("beat_accepted", 256'(ok), 256'd1);
    if (ok) model_beat(d, s, e);
  endtask

  task automatic send_pkt();
    for (int k = 0; k < 7; k++) applyStimulus(rand_fe(), k == 0, k == 6);
  endtask

  task automatic idle(input int n);
    in_if.val = 1'b0;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int w = 0; w < 200 && (exp_q.size() != 0 || out_if.val); w++) @(posedge i_clk);
    #1;
    checkOutput(tag, 256'(exp_q.size()), 256'd0);
  endtask

  task automatic do_reset();
    i_rst     = 1'b1;
    in_if.val = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    part_q.delete();
    exp_q.delete();
    model_err   = 0;
    model_batch = 0;
  endtask

  initial begin
    int trunc;
    n_checks  = 0;
    n_errors  = 0;
    model_err = 0;
    model_batch = 0;
    rnd_rdy   = 0;
    rdy_fixed = 1;
    i_rst     = 1'b1;
    num_in    = 64'd1;
    in_if.val = 1'b0; in_if.sop = 1'b0; in_if.eop = 1'b0; in_if.dat = '0; in_if.ctl = '0;
    out_if.rdy = 1'b1;
    sat_in_if.val = 1'b0; sat_in_if.sop = 1'b0; sat_in_if.eop = 1'b0;
    sat_in_if.dat = '0; sat_in_if.ctl = '0;
    sat_out_if.rdy = 1'b1;
    fork
      monitor_loop();
      rdy_loop();
    join_none

    do_reset();
    checkOutput("rst_out_val", 256'(out_if.val), 256'd0);
    checkOutput("rst_out_sop", 256'(out_if.sop), 256'd0);
    checkOutput("rst_out_eop", 256'(out_if.eop), 256'd0);
    checkOutput("rst_out_dat_any", 256'(|out_if.dat), 256'd0);
    checkOutput("rst_err_cnt", 256'(err_cnt), 256'd0);
    checkOutput("rst_in_rdy", 256'(in_if.rdy), 256'd1);

    // Single packet, num_in=1: sop=eop=1, output one cycle after eop.
    for (int k = 0; k < 7; k++) begin
      applyStimulus(fe_t'(32'h10 + k), k == 0, k == 6);
      if (k == 5) checkOutput("single_val_early", 256'(out_if.val), 256'd0);
    end
    checkOutput("single_val_latency", 256'(out_if.val), 256'd1);
    checkOutput("single_sop", 256'(out_if.sop), 256'd1);
    checkOutput("single_eop", 256'(out_if.eop), 256'd1);
    checkOutput("single_beat3", out_if.dat[3*256 +: 256], 256'h13);
    drain("single_drain");
    checkOutput("single_err", 256'(err_cnt), 256'(exp_err()));

    // Batch of 3 back-to-back plus a 4th that starts a new batch.
    num_in = 64'd3;
    out_times.delete();
    repeat (4) send_pkt();
    drain("batch_drain");
    checkOutput("batch_out_count", 256'(out_times.size()), 256'd4);
    if (out_times.size() == 4) begin
      checkOutput("batch_gap01", 256'(out_times[1] - out_times[0]), 256'd70);
      checkOutput("batch_gap12", 256'(out_times[2] - out_times[1]), 256'd70);
    end

    // Backpressure: hold the output while a second packet reaches its last beat.
    rdy_fixed = 0;
    idle(1);
    send_pkt();
    for (int k = 0; k < 6; k++) applyStimulus(rand_fe(), k == 0, 1'b0);
    begin
      fe_t last_beat;
      last_beat = rand_fe();
      in_if.dat = last_beat; in_if.sop = 1'b0; in_if.eop = 1'b1; in_if.val = 1'b1;
      for (int i = 0; i < 12; i++) begin
        @(negedge i_clk);
        #3;
        checkOutput("bp_in_rdy_low", 256'(in_if.rdy), 256'd0);
        @(posedge i_clk);
        #1;
      end
      rdy_fixed = 1;
      applyStimulus(last_beat, 1'b0, 1'b1);
    end
    drain("bp_drain");
    checkOutput("bp_err", 256'(err_cnt), 256'(exp_err()));

    // Framing errors: early eop, missing sop, restart mid-packet.
    out_times.delete();
    for (int k = 0; k < 4; k++) applyStimulus(rand_fe(), k == 0, k == 3);
    applyStimulus(rand_fe(), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(rand_fe(), k == 0, 1'b0);
    send_pkt();
    drain("frm_drain");
    checkOutput("frm_err", 256'(err_cnt), 256'(exp_err()));
    checkOutput("frm_err_abs", 256'(err_cnt), 256'd3);
    checkOutput("frm_out_count", 256'(out_times.size()), 256'd1);

    // Lone sop&eop beat is dropped.
    applyStimulus(rand_fe(), 1'b1, 1'b1);
    idle(3);
    checkOutput("se_no_out", 256'(out_if.val), 256'd0);
    checkOutput("se_err", 256'(err_cnt), 256'(exp_err()));

    // Reset in the middle of a packet.
    for (int k = 0; k < 4; k++) applyStimulus(rand_fe(), k == 0, 1'b0);
    do_reset();
    checkOutput("mid_rst_err", 256'(err_cnt), 256'd0);
    checkOutput("mid_rst_val", 256'(out_if.val), 256'd0);
    send_pkt();
    checkOutput("mid_rst_sop", 256'(out_if.sop), 256'd1);
    drain("mid_rst_drain");
    checkOutput("mid_rst_err2", 256'(err_cnt), 256'd0);

    // Unbounded batches: sop only once, eop never.
    do_reset();
    num_in = 64'd0;
    repeat (3) send_pkt();
    drain("unb_drain");

    // Randomized traffic with gaps, truncations and random output backpressure.
    do_reset();
    num_in  = 64'd4;
    rnd_rdy = 1;
    for (int p = 0; p < 24; p++) begin
      trunc = $urandom_range(0, 9);
      for (int k = 0; k < 7; k++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        applyStimulus(rand_fe(), k == 0, (k == 6) || (k == trunc));
        if (k == trunc) break;
      end
    end
    rnd_rdy   = 0;
    rdy_fixed = 1;
    drain("rnd_drain");
    checkOutput("rnd_err", 256'(err_cnt), 256'(exp_err()));

    // Saturation on the narrow-counter instance.
    sat_in_if.dat = rand_fe();
    sat_in_if.sop = 1'b1;
    sat_in_if.eop = 1'b1;
    sat_in_if.val = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge i_clk);
      #1;
      checkOutput($sformatf("sat_err_%0d", k), 256'(sat_err), 256'((k > 3) ? 3 : k));
    end
    sat_in_if.val = 1'b0;
    checkOutput("sat_no_out", 256'(sat_out_if.val), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
